prach_reshape_xpose: RTL and testbench

PRACH_RESHAPE_XPOSE -- requirements
Module: prach_reshape_xpose

---
 rtl/prach_reshape_xpose.sv | 152 +++++++++++++++
 tb/tb_prach_reshape_xpose.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prach_reshape_xpose.sv
// PRACH reshape: frame-aligned LANES x G transpose with HUNT/LOCKED sync tracking and a bypass mode.
// Optional saturating sync-error counter on err_cnt when PRACH_RESHAPE_ERR_CNT_EN is defined.
module prach_reshape_xpose #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int SIZE  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic                   din_valid,
  input  logic                   sync_in,
  input  logic                   bypass,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic [7:0]             dout_chn,
  output logic                   sync_out,
  output logic                   locked,
  output logic                   sync_err
`ifdef PRACH_RESHAPE_ERR_CNT_EN
  , output logic [15:0]          err_cnt
`endif
);

  localparam int G     = SIZE / LANES;
  localparam int LAT   = (LANES - 1) * G + 1;
  localparam int DEPTH = 2 * (LANES - 1) * G;
  localparam int SW    = $clog2(SIZE);
  localparam int KW    = $clog2(LANES);
  localparam int GW    = $clog2(G);
  localparam int FW    = $clog2(LAT + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_r;
  logic [SW-1:0]    cnt_r;
  logic [SW-1:0]    slot_s;
  logic [SW-1:0]    oslot_s;
  logic [FW-1:0]    fill_r;
  logic [FW-1:0]    fill_s;
  logic             byp_in_r;
  logic             byp_out_r;
  logic             byp_out_s;
  logic             acq_s;
  logic             mis_s;
  logic             lock_s;
  logic             vld_s;
  logic [KW-1:0]    ksel_s;
  logic [WIDTH-1:0] sr_r  [LANES][DEPTH];
  logic [WIDTH-1:0] tap_s [LANES][DEPTH+1];
  logic [LANES*WIDTH-1:0] xp_s;

  // Slot tracking, alignment decisions and output slot derivation for the current beat
  always_comb begin
    slot_s = sync_in ? '0 : cnt_r;
    acq_s  = din_valid && sync_in && (state_r == HUNT);
    mis_s  = din_valid && sync_in && (state_r == LOCKED) && (cnt_r != '0);
    lock_s = (state_r == LOCKED) || acq_s;
    if (acq_s || mis_s) begin
      fill_s = FW'(1);
    end else if (fill_r == FW'(LAT)) begin
      fill_s = fill_r;
    end else begin
      fill_s = fill_r + FW'(1);
    end
    // The output stream trails the input by (LANES-1)*G slots plus the output register.
    oslot_s   = slot_s - SW'((LANES - 1) * G);
    ksel_s    = KW'(oslot_s >> GW);
    byp_out_s = (oslot_s == '0) ? byp_in_r : byp_out_r;
    vld_s     = din_valid && lock_s && (fill_s == FW'(LAT));
  end

  // Tap d of lane k is the lane-k sample from d valid beats ago (tap 0 is din itself)
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      tap_s[k][0] = din[k*WIDTH +: WIDTH];
      for (int j = 1; j <= DEPTH; j++) begin
        tap_s[k][j] = sr_r[k][j-1];
      end
    end
  end

  // Output lane g takes source lane k from (k-g+LANES-1)*G beats back; bypass uses k == g
  always_comb begin
    xp_s = '0;
    for (int g = 0; g < LANES; g++) begin
      for (int k = 0; k < LANES; k++) begin
        xp_s[g*WIDTH +: WIDTH] =
          (byp_out_s ? (k == g) : (int'(ksel_s) == k)) ? tap_s[k][(k - g + LANES - 1) * G]
                                                       : xp_s[g*WIDTH +: WIDTH];
      end
    end
  end

  // Delay-line storage, advanced only on valid beats and intentionally left unreset
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int k = 0; k < LANES; k++) begin
        for (int j = 0; j < DEPTH; j++) begin
          sr_r[k][j] <= tap_s[k][j];
        end
      end
    end
  end

  // Alignment FSM, counters, bypass latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HUNT;
      cnt_r      <= '0;
      fill_r     <= '0;
      byp_in_r   <= 1'b0;
      byp_out_r  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_chn   <= 8'd0;
      sync_out   <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else if (din_valid) begin
      state_r    <= lock_s ? LOCKED : HUNT;
      locked     <= lock_s;
      cnt_r      <= slot_s + SW'(1);
      fill_r     <= fill_s;
      byp_in_r   <= (slot_s == '0) ? bypass : byp_in_r;
      byp_out_r  <= byp_out_s;
      sync_err   <= mis_s;
      dout_valid <= vld_s;
      sync_out   <= vld_s && (oslot_s == '0);
      if (vld_s) begin
        dout     <= xp_s;
        dout_chn <= 8'(oslot_s);
      end
    end else begin
      dout_valid <= 1'b0;
      sync_out   <= 1'b0;
      sync_err   <= 1'b0;
    end
  end

`ifdef PRACH_RESHAPE_ERR_CNT_EN
  // Saturating count of misaligned syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'h0000;
    end else if (mis_s && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_prach_reshape_xpose.sv
// Self-checking bench for prach_reshape_xpose: table-driven frames at default size plus a 4-lane instance.
module tb_prach_reshape_xpose;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] din;
  logic        din_valid, sync_in, bypass;
  logic [31:0] dout;
  logic        dout_valid;
  logic [7:0]  dout_chn;
  logic        sync_out, locked, sync_err;

  logic [63:0] w_din, w_dout;
  logic        w_valid, w_sync, w_dout_valid, w_sync_out, w_locked, w_sync_err;
  logic [7:0]  w_chn;
`ifdef PRACH_RESHAPE_ERR_CNT_EN
  logic [15:0] err_cnt, w_err_cnt;
`endif

  prach_reshape_xpose #(.WIDTH(16), .LANES(2), .SIZE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync_in(sync_in),
    .bypass(bypass), .dout(dout), .dout_valid(dout_valid), .dout_chn(dout_chn),
    .sync_out(sync_out), .locked(locked), .sync_err(sync_err)
`ifdef PRACH_RESHAPE_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  prach_reshape_xpose #(.WIDTH(16), .LANES(4), .SIZE(16)) u_wide (
    .clk(clk), .rst_n(rst_n), .din(w_din), .din_valid(w_valid), .sync_in(w_sync),
    .bypass(1'b0), .dout(w_dout), .dout_valid(w_dout_valid), .dout_chn(w_chn),
    .sync_out(w_sync_out), .locked(w_locked), .sync_err(w_sync_err)
`ifdef PRACH_RESHAPE_ERR_CNT_EN
    , .err_cnt(w_err_cnt)
`endif
  );

  typedef struct {
    logic        v, s, b;
    logic [31:0] d;
    logic        ev, echk, ezero, elock, eerr;
    logic [31:0] edout;
    logic [7:0]  echn;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cur    = 0;

  // Expected transposed lanes for one 2x8 frame with lane0=0x00..0x07, lane1=0x10..0x17
  logic [15:0] e_tab [0:1][0:7] = '{
    '{16'h00, 16'h01, 16'h02, 16'h03, 16'h10, 16'h11, 16'h12, 16'h13},
    '{16'h04, 16'h05, 16'h06, 16'h07, 16'h14, 16'h15, 16'h16, 16'h17}
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %0h, expected %0h", name, cur, act, exp);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, " dout"}, dout, 64'd0);
    chk({tag, " dout_valid"}, dout_valid, 64'd0);
    chk({tag, " dout_chn"}, dout_chn, 64'd0);
    chk({tag, " sync_out"}, sync_out, 64'd0);
    chk({tag, " locked"}, locked, 64'd0);
    chk({tag, " sync_err"}, sync_err, 64'd0);
    chk({tag, " wide_valid"}, w_dout_valid, 64'd0);
`ifdef PRACH_RESHAPE_ERR_CNT_EN
    chk({tag, " err_cnt"}, err_cnt, 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; sync_in = 1'b0; bypass = 1'b0;
    w_valid = 1'b0; w_sync = 1'b0; din = 32'd0; w_din = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    zero_chk("reset");
    rst_n = 1'b1;
  endtask

  // Fill the table: hunt unsynced beats, then nbeats framed beats; mis = framed beat of a misaligned sync
  task automatic build(input int hunt, input int nbeats, input bit gaps, input int mis, input logic [7:0] bmask);
    int i = 0, cyc = 0, fs = 0, seg = 0, ecnt = 0;
    logic lk = 1'b0;
    tbl.delete();
    while (i < hunt + nbeats) begin
      vec_t r;
      r = '{default: '0};
      if (gaps && (cyc % 3 == 2)) begin
        r.d = 32'hDEAD_BEEF; r.elock = lk; r.ecnt = 16'(ecnt);
      end else begin
        r.v = 1'b1;
        if (i < hunt) begin
          r.d = 32'h0BAD_0BAD; r.ezero = 1'b1; r.ecnt = 16'(ecnt);
        end else begin
          int rel0, rel, fr, s, base, j, of, t, ob;
          logic fb, obyp;
          rel0 = i - hunt;
          if (rel0 == mis) begin seg++; fs = rel0; ecnt++; r.eerr = 1'b1; end
          rel  = rel0 - fs;
          fr   = rel / 8;
          s    = rel % 8;
          fb   = bmask[fr % 8];
          r.s  = (s == 0);
          r.b  = (s >= 4) ? !fb : fb;
          base = seg * 256 + fr * 32;
          r.d  = {16'(base + 16 + s), 16'(base + s)};
          lk   = 1'b1;
          r.elock = 1'b1;
          r.ecnt  = 16'(ecnt);
          j = rel - 4;
          if (j >= 0) begin
            of   = j / 8;
            t    = j % 8;
            ob   = seg * 256 + of * 32;
            obyp = bmask[of % 8];
            r.ev = 1'b1; r.echk = 1'b1; r.echn = 8'(t);
            r.edout = obyp ? {16'(ob + 16 + t), 16'(ob + t)}
                           : {16'(ob) + e_tab[1][t], 16'(ob) + e_tab[0][t]};
          end else begin
            r.ezero = (seg == 0);
          end
        end
        i++;
      end
      tbl.push_back(r);
      cyc++;
    end
  endtask

  task automatic apply();
    foreach (tbl[n]) begin
      cur = n;
      din = tbl[n].d; din_valid = tbl[n].v; sync_in = tbl[n].s; bypass = tbl[n].b;
      @(posedge clk);
      #1;
      chk("dout_valid", dout_valid, tbl[n].ev);
      chk("locked", locked, tbl[n].elock);
      chk("sync_err", sync_err, tbl[n].eerr);
      chk("sync_out", sync_out, tbl[n].ev && (tbl[n].echn == 8'd0));
      if (tbl[n].echk) begin
        chk("dout", dout, tbl[n].edout);
        chk("dout_chn", dout_chn, tbl[n].echn);
      end
      if (tbl[n].ezero) chk("dout_before_valid", dout, 64'd0);
`ifdef PRACH_RESHAPE_ERR_CNT_EN
      chk("err_cnt", err_cnt, tbl[n].ecnt);
`endif
    end
    din_valid = 1'b0; sync_in = 1'b0;
  endtask

  initial begin
    do_reset();

    // Transpose after a few unsynced HUNT beats; bypass toggles mid-frame without effect
    build(3, 24, 1'b0, -1, 8'h00);
    apply();

    // Reset asserted asynchronously while presenting slot 5 of the second frame
    do_reset();
    build(0, 13, 1'b0, -1, 8'h00);
    apply();
    din = {16'h0035, 16'h0025}; din_valid = 1'b1; sync_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    zero_chk("async_reset");
    do_reset();

    // Gaps: valid low every third cycle
    build(0, 24, 1'b1, -1, 8'h00);
    apply();

    // Misaligned sync at slot 3 of the second frame
    do_reset();
    build(0, 30, 1'b0, 11, 8'h00);
    apply();

    // Bypass on frames 0 and 2, transpose on frame 1
    do_reset();
    build(0, 32, 1'b0, -1, 8'h05);
    apply();

    // Wide instance: 4 lanes, 16 slots, latency 13
    do_reset();
    for (int i = 0; i < 32; i++) begin
      int s;
      cur = 1000 + i;
      s = i % 16;
      for (int k = 0; k < 4; k++) w_din[k*16 +: 16] = 16'(k * 256 + s);
      w_valid = 1'b1;
      w_sync  = (s == 0);
      @(posedge clk);
      #1;
      chk("wide_valid", w_dout_valid, (i >= 12) ? 64'd1 : 64'd0);
      if (i >= 12) begin
        int t, kk, o;
        logic [63:0] e;
        t  = (i - 12) % 16;
        kk = t / 4;
        o  = t % 4;
        for (int g = 0; g < 4; g++) e[g*16 +: 16] = 16'(kk * 256 + g * 4 + o);
        chk("wide_dout", w_dout, e);
        chk("wide_chn", w_chn, 64'(t));
        chk("wide_sync_out", w_sync_out, (t == 0) ? 64'd1 : 64'd0);
      end
    end
    w_valid = 1'b0; w_sync = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
